hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing block for the 5-stage MIPS core. It sits beside the forwarding unit in ID/EX.
- Detects hazards that forwarding cannot resolve and drives the stall, bubble and flush controls for the IF/ID and ID/EX registers and the PC:
  - load-use stall,
  - multi-cycle mult/div occupancy of EX,
  - taken-branch flush.

Parameters:
- len, 32: register file depth.
- NB, $clog2(len): register index width.
- MULDIV_CYCLES, 8: total cycles a mult/div instruction occupies EX. Must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read_2_3  in  1  instruction in ID/EX is a load.
- rt_2_3  in  NB  destination of the load in ID/EX.
- muldiv_start_2_3  in  1  instruction in ID/EX is mult/div.
- branch_taken_2_3  in  1  branch in EX resolved taken.
- rs_1_2  in  NB  rs of the instruction in IF/ID.
- rt_1_2  in  NB  rt of the instruction in IF/ID.
- uses_rt_1_2  in  1  IF/ID instruction reads rt as a source.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register load enable.
- id_ex_write  out  1  ID/EX register load enable.
- bubble_2_3  out  1  zero the control bits entering ID/EX.
- flush_1_2  out  1  clear IF/ID to a NOP.
- muldiv_done  out  1  one-cycle pulse on the last mult/div EX cycle.

Behaviour:
- FSM states: RUN, MULDIV_WAIT. Internal down-counter cnt, width $clog2(MULDIV_CYCLES).
- Outputs are combinational from state, cnt and inputs.
- Default output set, RUN with no event: pc_write=1, if_id_write=1, id_ex_write=1, bubble_2_3=0, flush_1_2=0, muldiv_done=0.
- load_use condition: mem_read_2_3 & rt_2_3!=0 & (rt_2_3==rs_1_2 | (uses_rt_1_2 & rt_2_3==rt_1_2)).
- RUN priority, highest first:
  1. muldiv_start_2_3=1: pc_write=0, if_id_write=0, id_ex_write=0. Next state MULDIV_WAIT, cnt <= MULDIV_CYCLES-2.
  2. branch_taken_2_3=1: flush_1_2=1, bubble_2_3=1, pc_write=1. A load_use in the same cycle is ignored, since the IF/ID instruction is wrong-path.
  3. load_use: pc_write=0, if_id_write=0, bubble_2_3=1, id_ex_write=1. Single-cycle stall; the FSM stays in RUN. The hazard clears the next cycle because the load advances to EX/MEM.
- MULDIV_WAIT:
  - cnt!=0: pc_write=0, if_id_write=0, id_ex_write=0, cnt decrements.
  - cnt==0: default output set with muldiv_done=1; next state RUN.
  - muldiv_start_2_3, branch_taken_2_3 and load_use are all ignored in MULDIV_WAIT, because the held instruction keeps asserting start.
  - Result: the mult/div instruction occupies EX for exactly MULDIV_CYCLES cycles, and the stall lasts MULDIV_CYCLES-1 cycles.
- Register 0 never causes a load-use stall.
- Reset:
  - rst_n low, at any time including mid MULDIV_WAIT: state RUN and cnt=0 immediately (asynchronous).
  - While rst_n is low: pc_write=0, if_id_write=0, id_ex_write=0, bubble_2_3=1, flush_1_2=0, muldiv_done=0.
  - After release, the first rising edge evaluates normally.

Optional Feature:
- Macro HAZARD_STALL_PERF_CNT_EN.
- When defined:
  - Extra output port stall_cycles, out, 32 bits.
  - Cleared by reset.
  - Increments on every rising edge where pc_write=0 and rst_n=1.
  - Saturates at 32'hFFFF_FFFF.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: mem_read_2_3=1, rt_2_3=5, rs_1_2=5 for one cycle -> pc_write=0, if_id_write=0, bubble_2_3=1 that cycle only. Repeat with rt_2_3=0 -> no stall.
- rt-only hazard: rt_2_3=7, rt_1_2=7, rs_1_2=3, toggle uses_rt_1_2 -> stall only when uses_rt_1_2=1.
- Mult/div with MULDIV_CYCLES=8: hold muldiv_start_2_3=1 -> pc_write=0 for exactly 7 consecutive cycles; muldiv_done=1 on the 8th cycle with pc_write=1; state back to RUN.
- Simultaneous branch_taken_2_3=1 and load_use -> flush_1_2=1, bubble_2_3=1, pc_write=1, if_id_write=1.
- Reset asserted at cycle 3 of MULDIV_WAIT -> outputs immediately take reset values; after release with no events -> default output set, no residual stall.
- With HAZARD_STALL_PERF_CNT_EN: one load-use stall plus one 8-cycle mult/div -> stall_cycles=8.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Hazard stall controller for the 5-stage MIPS pipeline: load-use stall, mult/div EX occupancy, taken-branch flush.
// Optional stall-cycle performance counter enabled by defining HAZARD_STALL_PERF_CNT_EN.
module hazard_stall_controller #(
  parameter int len           = 32,
  parameter int NB            = $clog2(len),
  parameter int MULDIV_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read_2_3,
  input  logic [NB-1:0] rt_2_3,
  input  logic          muldiv_start_2_3,
  input  logic          branch_taken_2_3,
  input  logic [NB-1:0] rs_1_2,
  input  logic [NB-1:0] rt_1_2,
  input  logic          uses_rt_1_2,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          id_ex_write,
  output logic          bubble_2_3,
  output logic          flush_1_2,
  output logic          muldiv_done
`ifdef HAZARD_STALL_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  localparam int CW = $clog2(MULDIV_CYCLES);

  typedef enum logic {RUN, MULDIV_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load_use;

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = mem_read_2_3 && (rt_2_3 != '0) &&
                    ((rt_2_3 == rs_1_2) || (uses_rt_1_2 && (rt_2_3 == rt_1_2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (muldiv_start_2_3) begin
            state <= MULDIV_WAIT;
            cnt   <= CW'(MULDIV_CYCLES - 2);
          end
        end
        MULDIV_WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= RUN;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs are level controls evaluated every cycle; no handshake is involved.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    bubble_2_3  = 1'b0;
    flush_1_2   = 1'b0;
    muldiv_done = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      bubble_2_3  = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (muldiv_start_2_3) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
          end else if (branch_taken_2_3) begin
            // The IF/ID instruction is wrong-path, so any load-use against it is moot.
            flush_1_2  = 1'b1;
            bubble_2_3 = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble_2_3  = 1'b1;
          end
        end
        MULDIV_WAIT: begin
          if (cnt != '0) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
          end else begin
            muldiv_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (!pc_write && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: driver pushes expected controls, a negedge monitor pops and compares.
// Also checks the stall counter when HAZARD_STALL_PERF_CNT_EN is defined.
module tb_hazard_stall_controller;

  localparam int NB = 5;

  // Expected output vector order: {pc_write, if_id_write, id_ex_write, bubble_2_3, flush_1_2, muldiv_done}
  localparam logic [5:0] E_DEF  = 6'b111000;
  localparam logic [5:0] E_RST  = 6'b000100;
  localparam logic [5:0] E_LU   = 6'b001100;
  localparam logic [5:0] E_BR   = 6'b111110;
  localparam logic [5:0] E_MD   = 6'b000000;
  localparam logic [5:0] E_DONE = 6'b111001;

  logic          clk;
  logic          rst_n;
  logic          mem_read_2_3;
  logic [NB-1:0] rt_2_3;
  logic          muldiv_start_2_3;
  logic          branch_taken_2_3;
  logic [NB-1:0] rs_1_2;
  logic [NB-1:0] rt_1_2;
  logic          uses_rt_1_2;
  logic          pc_write;
  logic          if_id_write;
  logic          id_ex_write;
  logic          bubble_2_3;
  logic          flush_1_2;
  logic          muldiv_done;
`ifdef HAZARD_STALL_PERF_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  hazard_stall_controller #(.len(32), .NB(NB), .MULDIV_CYCLES(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_read_2_3     (mem_read_2_3),
    .rt_2_3           (rt_2_3),
    .muldiv_start_2_3 (muldiv_start_2_3),
    .branch_taken_2_3 (branch_taken_2_3),
    .rs_1_2           (rs_1_2),
    .rt_1_2           (rt_1_2),
    .uses_rt_1_2      (uses_rt_1_2),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .id_ex_write      (id_ex_write),
    .bubble_2_3       (bubble_2_3),
    .flush_1_2        (flush_1_2),
    .muldiv_done      (muldiv_done)
`ifdef HAZARD_STALL_PERF_CNT_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [5:0] exp_q[$];
  string      tag_q[$];
  int         checks;
  int         errors;

  // Driver: apply one cycle of inputs just after the rising edge and queue the expectation.
  task automatic drive(input logic rst, input logic mr, input logic [NB-1:0] rt23,
                       input logic ms, input logic bt, input logic [NB-1:0] rs12,
                       input logic [NB-1:0] rt12, input logic urt,
                       input logic [5:0] exp, input string tag);
    @(posedge clk);
    #1;
    rst_n            = rst;
    mem_read_2_3     = mr;
    rt_2_3           = rt23;
    muldiv_start_2_3 = ms;
    branch_taken_2_3 = bt;
    rs_1_2           = rs12;
    rt_1_2           = rt12;
    uses_rt_1_2      = urt;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input logic [5:0] exp, input string tag);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, exp, tag);
  endtask

  // Full mult/div: 7 stall cycles then the done cycle; events in the wait phase must be ignored.
  task automatic muldiv_run(input string tag);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, E_MD, {tag, "_start"});
    for (int i = 0; i < 6; i++) begin
      if (i == 2)
        drive(1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, '0, 1'b0, E_MD, {tag, "_wait_ignore"});
      else
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, E_MD, {tag, "_wait"});
    end
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, E_DONE, {tag, "_done"});
  endtask

  // Scoreboard monitor
  logic [5:0] mon_exp;
  logic [5:0] mon_act;
  string      mon_tag;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {pc_write, if_id_write, id_ex_write, bubble_2_3, flush_1_2, muldiv_done};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (pc,ifid,idex,bubble,flush,done)", mon_tag, mon_act, mon_exp);
      end
    end
  end

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    mem_read_2_3     = 1'b0;
    rt_2_3           = '0;
    muldiv_start_2_3 = 1'b0;
    branch_taken_2_3 = 1'b0;
    rs_1_2           = '0;
    rt_1_2           = '0;
    uses_rt_1_2      = 1'b0;

    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, E_RST, "reset_0");
    drive(1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, '0, 1'b0, E_RST, "reset_inputs_busy");
    idle(E_DEF, "release_idle");

    drive(1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd5, '0, 1'b0, E_LU, "load_use_rs");
    idle(E_DEF, "load_use_clears");
    drive(1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, E_DEF, "load_r0_no_stall");
    drive(1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd5, '0, 1'b0, E_DEF, "no_mem_read");

    drive(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd3, 5'd7, 1'b0, E_DEF, "rt_unused");
    drive(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd3, 5'd7, 1'b1, E_LU, "rt_used");
    idle(E_DEF, "rt_clears");

    muldiv_run("md1");
    idle(E_DEF, "md1_back_run");

    drive(1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 5'd4, '0, 1'b0, E_BR, "branch_over_load_use");
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, '0, '0, 1'b0, E_BR, "branch_alone");
    drive(1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 5'd4, '0, 1'b0, E_MD, "muldiv_over_branch");
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, E_MD, "md2_wait");
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, E_DONE, "md2_done");

    // Reset during the third MULDIV_WAIT cycle
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, E_MD, "md3_start");
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, E_MD, "md3_wait1");
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, E_MD, "md3_wait2");
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, E_RST, "md3_reset_mid");
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, E_RST, "md3_reset_hold");
    idle(E_DEF, "post_reset_idle0");
    idle(E_DEF, "post_reset_idle1");
    idle(E_DEF, "post_reset_idle2");

    drive(1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 5'd1, 5'd12, 1'b1, E_LU, "perf_load_use");
    idle(E_DEF, "perf_gap");
    muldiv_run("md4");
    idle(E_DEF, "tail_idle0");
    idle(E_DEF, "tail_idle1");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
    end
    #2;

`ifdef HAZARD_STALL_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd8) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected 8", stall_cycles);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
